// File: rtl/cubic_stream_reducer_pkg.sv
// Shared types for the cubic stream reducer: AXI-Stream beat structs, FSM states, summary length.
// Optional build macro CUBIC_REDUCER_MEAN_EN adds a fourth summary beat carrying sum/count.
package cubic_stream_pkg;

    localparam int REAL_BITS = 64;

`ifdef CUBIC_REDUCER_MEAN_EN
    localparam int SUMMARY_BEATS = 4;
`else
    localparam int SUMMARY_BEATS = 3;
`endif

    typedef struct packed {
        logic [REAL_BITS-1:0] tdata;
        logic                 tvalid;
        logic                 tlast;
    } axi_stream_mastero_slavei_t;

    typedef struct packed {
        logic tready;
    } axi_stream_masteri_slaveo_t;

    typedef enum logic [2:0] {
        ACC      = 3'd0,
        EMIT_SUM = 3'd1,
        EMIT_MIN = 3'd2,
`ifdef CUBIC_REDUCER_MEAN_EN
        EMIT_MAX  = 3'd3,
        EMIT_MEAN = 3'd4
`else
        EMIT_MAX  = 3'd3
`endif
    } reducer_state_t;

    // The state whose handshake closes the summary packet.
    function automatic logic is_final_beat(reducer_state_t s);
`ifdef CUBIC_REDUCER_MEAN_EN
        return s == EMIT_MEAN;
`else
        return s == EMIT_MAX;
`endif
    endfunction

endpackage

// File: rtl/cubic_stream_reducer_if.sv
// AXI-Stream link used on both sides of the reducer: mo carries TDATA/TVALID/TLAST, so carries TREADY.
interface cubic_stream_reducer_if;
    import cubic_stream_pkg::*;

    axi_stream_mastero_slavei_t mo;
    axi_stream_masteri_slaveo_t so;

    modport master (output mo, input so);
    modport slave  (input mo, output so);
endinterface

// File: rtl/cubic_stream_reducer_acc.sv
// Per-packet sum/min/max/count accumulator. Outputs show the value including the current
// cycle's load/clear, so the FSM can latch a packet summary on the same edge as TLAST.
module cubic_reduce_acc
    import cubic_stream_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 first,
    input  logic                 clear,
    input  logic [REAL_BITS-1:0] x,
    output logic [REAL_BITS-1:0] sum,
    output logic [REAL_BITS-1:0] min,
    output logic [REAL_BITS-1:0] max,
    output logic [COUNT_W-1:0]   count,
    output logic                 sat
);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [REAL_BITS-1:0] sum_q;
    logic [REAL_BITS-1:0] min_q;
    logic [REAL_BITS-1:0] max_q;
    logic [COUNT_W-1:0]   count_q;
    logic                 sat_q;

    // A NaN sample fails both compares, so min/max hold while the sum turns NaN.
    always_comb begin
        sum   = sum_q;
        min   = min_q;
        max   = max_q;
        count = count_q;
        sat   = sat_q;
        if (clear) begin
            sum   = '0;
            min   = '0;
            max   = '0;
            count = '0;
            sat   = 1'b0;
        end else if (load) begin
            if (first) begin
                sum   = x;
                min   = x;
                max   = x;
                count = COUNT_W'(1);
            end else begin
                sum = $realtobits($bitstoreal(sum_q) + $bitstoreal(x));
                if ($bitstoreal(x) < $bitstoreal(min_q)) min = x;
                if ($bitstoreal(x) > $bitstoreal(max_q)) max = x;
                if (count_q == COUNT_MAX) sat = 1'b1;
                else                      count = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            sum_q   <= sum;
            min_q   <= min;
            max_q   <= max;
            count_q <= count;
            sat_q   <= sat;
        end
    end
endmodule

// File: rtl/cubic_stream_reducer.sv
// Reduces TLAST-delimited packets of 64-bit reals to a sum/min/max summary packet
// (plus sum/count when built with CUBIC_REDUCER_MEAN_EN). Upstream stalls while emitting.
module cubic_stream_reducer
    import cubic_stream_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    cubic_stream_reducer_if.slave  prev,
    cubic_stream_reducer_if.master next,
    output logic [COUNT_W-1:0]     pkt_beats,
    output logic                   pkt_sat
);
    reducer_state_t             state;
    axi_stream_mastero_slavei_t nexto_q;
    logic                       first_q;
    logic                       accept;
    logic                       clear;

    logic [REAL_BITS-1:0] acc_sum;
    logic [REAL_BITS-1:0] acc_min;
    logic [REAL_BITS-1:0] acc_max;
    logic [COUNT_W-1:0]   acc_count;
    logic                 acc_sat;

    assign prev.so = '{tready: (state == ACC) && !rst};
    assign next.mo = nexto_q;
    assign accept  = prev.mo.tvalid && prev.so.tready;
    assign clear   = is_final_beat(state) && next.so.tready;

    cubic_reduce_acc #(.COUNT_W(COUNT_W)) u_acc (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .first (first_q),
        .clear (clear),
        .x     (prev.mo.tdata),
        .sum   (acc_sum),
        .min   (acc_min),
        .max   (acc_max),
        .count (acc_count),
        .sat   (acc_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            nexto_q   <= '0;
            pkt_beats <= '0;
            pkt_sat   <= 1'b0;
            first_q   <= 1'b1;
        end else begin
            if (accept) first_q <= 1'b0;
            case (state)
                ACC: begin
                    if (accept && prev.mo.tlast) begin
                        state     <= EMIT_SUM;
                        pkt_beats <= acc_count;
                        pkt_sat   <= acc_sat;
                        nexto_q   <= '{tdata: acc_sum, tvalid: 1'b1, tlast: 1'b0};
                    end
                end
                EMIT_SUM: begin
                    if (next.so.tready) begin
                        state         <= EMIT_MIN;
                        nexto_q.tdata <= acc_min;
                    end
                end
                EMIT_MIN: begin
                    if (next.so.tready) begin
                        state         <= EMIT_MAX;
                        nexto_q.tdata <= acc_max;
                        nexto_q.tlast <= (SUMMARY_BEATS == 3);
                    end
                end
`ifdef CUBIC_REDUCER_MEAN_EN
                EMIT_MAX: begin
                    if (next.so.tready) begin
                        state         <= EMIT_MEAN;
                        nexto_q.tdata <= $realtobits($bitstoreal(acc_sum) / real'(acc_count));
                        nexto_q.tlast <= 1'b1;
                    end
                end
                EMIT_MEAN: begin
                    if (next.so.tready) begin
                        state   <= ACC;
                        nexto_q <= '0;
                        first_q <= 1'b1;
                    end
                end
`else
                EMIT_MAX: begin
                    if (next.so.tready) begin
                        state   <= ACC;
                        nexto_q <= '0;
                        first_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state   <= ACC;
                    nexto_q <= '0;
                    first_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/cubic_stream_reducer.md
Name: cubic_stream_reducer

Overview:
- Downstream consumer of the Horner cubic pipeline output stream (cdtbo/cdtbi side).
- Accepts TLAST-delimited packets of real-valued samples (64-bit IEEE-754 in TDATA) and accumulates sum, min and max per packet.
- After each packet it emits a summary packet of beats on its own AXI-Stream master port, then returns to accumulation.
- Real arithmetic via $bitstoreal/$realtobits, same simulation-level datapath as the cubic stages.

Parameters:
COUNT_W, 16, width of per-packet beat counter; counter saturates at 2^COUNT_W-1

Ports:
clk  input  1  clock
rst  input  1  reset; one clock, reset asynchronous and active-high
previ  input  axi_stream_mastero_slavei_t  upstream TDATA/TVALID/TLAST (from cubic pipeline)
prevo  output  axi_stream_masteri_slaveo_t  upstream TREADY
nexti  input  axi_stream_masteri_slaveo_t  downstream TREADY
nexto  output  axi_stream_mastero_slavei_t  summary stream TDATA/TVALID/TLAST
pkt_beats  output  COUNT_W  beat count of last completed packet, valid while emitting
pkt_sat  output  1  count saturated in last completed packet

Behaviour:
- States: ACC, EMIT_SUM, EMIT_MIN, EMIT_MAX (plus EMIT_MEAN with feature). Reset state ACC.
- Reset (async, any state): state=ACC, sum/min/max=0.0, count=0, sat=0, nexto.TVALID/TDATA/TLAST=0, pkt_beats=0, pkt_sat=0. prevo.TREADY=0 while rst high.
- prevo.TREADY = (state==ACC) && !rst, combinational from state.
- Upstream accept = previ.TVALID && prevo.TREADY at posedge clk.
- Accept with count==0: sum=min=max=x, count=1.
- Accept with count>0: sum+=x; min=x if x<min; max=x if x>max; count+=1, saturating at 2^COUNT_W-1; sat set when an increment is attempted at max.
- NaN input: comparisons false, so min/max are unchanged; sum becomes NaN.
- Accept with TLAST: latch pkt_beats/pkt_sat, go to EMIT_SUM. First summary beat is valid on the next cycle (latency 1 clk from the last input handshake).
- EMIT_x: nexto.TVALID=1, TDATA=$realtobits(value), TLAST=0 except on the final summary beat.
  - Advance only on nexti.TREADY.
  - TDATA/TLAST/TVALID held stable while TREADY is low; no timeout.
- Final beat (EMIT_MAX, or EMIT_MEAN): TLAST=1. Its handshake clears sum/min/max/count/sat and returns to ACC. Next upstream accept is possible in that same following cycle (no bubble beyond the state change).
- Summary beats are registered outputs. After the last handshake, nexto returns to TVALID=0, TDATA=0, TLAST=0.
- Upstream is stalled for the whole emit phase. Back-to-back packets cost 3 (or 4) cycles of stall minimum.
- Reset mid-emit: summary discarded, no partial beat completes, state ACC.
- Bench-only checks: $error on TLAST without TVALID upstream; $error if nexto changes while TVALID && !TREADY.

Optional Feature:
- Macro CUBIC_REDUCER_MEAN_EN.
- Defined: EMIT_MEAN state follows EMIT_MAX, emitting sum/count as real. TLAST moves from the max beat to the mean beat (4 beats per packet).
- Undefined: 3 beats, TLAST on max; EMIT_MEAN state and divider absent.

Decomposition:
- Package cubic_stream_pkg:
  - reducer_state_t enum (logic [2:0]).
  - Localparams SUMMARY_BEATS (3 or 4 per macro).
  - REAL_BITS=64.
- Datapath registers and compare/add live in sub-module cubic_reduce_acc, with inputs clk, rst, load, first, x and outputs sum, min, max, count, sat. The top holds the FSM and the AXI outputs.

Test Plan:
- Packet 1.0, -2.0, 3.5 (TLAST on 3.5), TREADY=1 -> summary beats 2.5, -2.0, 3.5; TLAST only on 3.5; pkt_beats=3; first summary TVALID 1 clk after last accept.
- Single-beat packet 7.0 with TLAST -> 7.0, 7.0, 7.0; pkt_beats=1, pkt_sat=0.
- Same 3-beat packet, nexti.TREADY low 5 cycles during EMIT_MIN -> TDATA stays bits(-2.0), TVALID=1, prevo.TREADY=0 throughout; no beat lost or duplicated.
- Back-to-back packets [1.0, 2.0] then [-4.0]; upstream TVALID held -> summaries 3.0, 1.0, 2.0 then -4.0, -4.0, -4.0; second packet not merged into the first.
- COUNT_W=2, 5-beat packet of 1.0 -> sum 5.0, pkt_beats=3, pkt_sat=1.
- Async rst pulse mid-EMIT_SUM -> nexto zeroed immediately. A following packet [0.5] yields 0.5, 0.5, 0.5. With CUBIC_REDUCER_MEAN_EN, packet 1.0, -2.0, 3.5 gives a 4th beat 0.8333333 carrying TLAST.
